tvip_clock_gen_ctrl: RTL and testbench

//  Synthesizable clock-generation sequencer. Derives a divided clock (clk_out) from clk

---
 rtl/tvip_clock_gen_ctrl.sv | 115 +++++++++++
 tb/tb_tvip_clock_gen_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tvip_clock_gen_ctrl.sv
// Clock-generation sequencer: divided clock with a programmable half-period and edge strobes.
// Start, stop and divisor changes take effect only on half-period boundaries.
module tvip_clock_gen_ctrl #(
   parameter int unsigned DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_req,
   input  logic                 stop_req,
   input  logic                 div_valid,
   input  logic [DIV_WIDTH-1:0] div_value,
   output logic                 div_ready,
   output logic                 running,
   output logic                 clk_out,
   output logic                 clk_rise,
   output logic                 clk_fall
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STOPPING
   } state_t;

   state_t               state;
   logic [DIV_WIDTH-1:0] active;
   logic [DIV_WIDTH-1:0] pending;
   logic                 pend_valid;
   logic [DIV_WIDTH-1:0] cnt;

   logic [DIV_WIDTH-1:0] div_eff;
   logic [DIV_WIDTH-1:0] next_active;
   logic [DIV_WIDTH-1:0] start_active;
   logic                 div_acc;
   logic                 start_ok;
   logic                 toggle;
   logic                 stop_next;

   always_comb begin
      div_eff      = (div_value == '0) ? DIV_WIDTH'(1) : div_value;
      div_ready    = ~pend_valid;
      running      = (state != IDLE);
      div_acc      = div_valid & div_ready;
      start_ok     = start_req & ~stop_req;
      toggle       = (state != IDLE) && (cnt == '0);
      next_active  = pend_valid ? pending : active;
      start_active = div_acc ? div_eff : active;
      // Stop intent survives in STOPPING unless a lone start_req cancels it.
      stop_next    = stop_req | ((state == STOPPING) & ~start_req);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         clk_out    <= 1'b0;
         clk_rise   <= 1'b0;
         clk_fall   <= 1'b0;
         active     <= DIV_WIDTH'(1);
         pending    <= '0;
         pend_valid <= 1'b0;
         cnt        <= '0;
      end else begin
         clk_rise <= 1'b0;
         clk_fall <= 1'b0;
         case (state)
            IDLE: begin
               if (div_acc)
                  active <= div_eff;
               if (start_ok) begin
                  state    <= RUN;
                  clk_out  <= 1'b1;
                  clk_rise <= 1'b1;
                  cnt      <= start_active - DIV_WIDTH'(1);
               end
            end
            RUN, STOPPING: begin
               if (state == RUN && stop_req && !clk_out) begin
                  state      <= IDLE;
                  pend_valid <= 1'b0;
                  cnt        <= '0;
               end else if (toggle) begin
                  active     <= next_active;
                  cnt        <= next_active - DIV_WIDTH'(1);
                  pend_valid <= 1'b0;
                  clk_out    <= ~clk_out;
                  if (clk_out)
                     clk_fall <= 1'b1;
                  else
                     clk_rise <= 1'b1;
                  // Only a falling toggle can end a stop: low-phase stops exit above.
                  if (stop_next && clk_out) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else begin
                     state <= RUN;
                     if (div_acc) begin
                        pending    <= div_eff;
                        pend_valid <= 1'b1;
                     end
                  end
               end else begin
                  cnt   <= cnt - DIV_WIDTH'(1);
                  state <= stop_next ? STOPPING : RUN;
                  if (div_acc) begin
                     pending    <= div_eff;
                     pend_valid <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tvip_clock_gen_ctrl.sv
// Directed self-checking bench for tvip_clock_gen_ctrl; expected waveforms are hand-derived
// bit vectors where bit i is the value sampled just after the i-th captured edge.
module tb_tvip_clock_gen_ctrl;

   logic       clk;
   logic       rst;
   logic       start_req;
   logic       stop_req;
   logic       div_valid;
   logic [7:0] div_value;
   logic       div_ready;
   logic       running;
   logic       clk_out;
   logic       clk_rise;
   logic       clk_fall;

   int n_tests;
   int n_fail;

   tvip_clock_gen_ctrl #(.DIV_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_req (start_req),
      .stop_req  (stop_req),
      .div_valid (div_valid),
      .div_value (div_value),
      .div_ready (div_ready),
      .running   (running),
      .clk_out   (clk_out),
      .clk_rise  (clk_rise),
      .clk_fall  (clk_fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      start_req = 1'b0;
      stop_req  = 1'b0;
      div_valid = 1'b0;
      rst       = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
   endtask

   task automatic set_div(input logic [7:0] v);
      div_valid = 1'b1;
      div_value = v;
      tick();
   endtask

   task automatic capture(input int n, output logic [31:0] co, output logic [31:0] ri,
                          output logic [31:0] fa, output logic [31:0] rdy,
                          output logic [31:0] run);
      co = '0; ri = '0; fa = '0; rdy = '0; run = '0;
      for (int i = 0; i < n; i++) begin
         co[i]  = clk_out;
         ri[i]  = clk_rise;
         fa[i]  = clk_fall;
         rdy[i] = div_ready;
         run[i] = running;
         tick();
      end
   endtask

   logic [31:0] co, ri, fa, rdy, run;

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b0;
      start_req = 1'b0;
      stop_req  = 1'b0;
      div_valid = 1'b0;
      div_value = '0;
      #2;

      // Reset state
      do_reset();
      check("rst_clk_out", clk_out, 0);
      check("rst_running", running, 0);
      check("rst_ready", div_ready, 1);
      check("rst_strobes", {clk_rise, clk_fall}, 0);

      // Simultaneous start+stop in IDLE does nothing
      start_req = 1'b1; stop_req = 1'b1;
      tick();
      check("both_idle_run", {running, clk_out, clk_rise}, 0);

      // T1: div=3
      set_div(8'd3);
      start_req = 1'b1;
      tick();
      capture(12, co, ri, fa, rdy, run);
      check("t1_clk_out", co, 32'h1C7);
      check("t1_rise", ri, 32'h041);
      check("t1_fall", fa, 32'h208);
      check("t1_running", run, 32'hFFF);

      // T2: div=0 accepted together with start, overriding active=5
      do_reset();
      set_div(8'd5);
      div_valid = 1'b1; div_value = 8'd0; start_req = 1'b1;
      tick();
      capture(6, co, ri, fa, rdy, run);
      check("t2_clk_out", co, 32'h15);
      check("t2_rise", ri, 32'h15);
      check("t2_fall", fa, 32'h2A);

      // T3: div=4, update to 2 in cycle 1 of high phase
      do_reset();
      set_div(8'd4);
      start_req = 1'b1;
      tick();
      div_valid = 1'b1; div_value = 8'd2;
      tick();
      capture(9, co, ri, fa, rdy, run);
      check("t3_clk_out", co, 32'h67);
      check("t3_rise", ri, 32'h20);
      check("t3_fall", fa, 32'h88);
      check("t3_ready", rdy, 32'h1F8);

      // T4: stop in cycle 1 of high phase
      do_reset();
      set_div(8'd4);
      start_req = 1'b1;
      tick();
      stop_req = 1'b1;
      tick();
      capture(8, co, ri, fa, rdy, run);
      check("t4_clk_out", co, 32'h07);
      check("t4_rise", ri, 32'h00);
      check("t4_fall", fa, 32'h08);
      check("t4_running", run, 32'h07);

      // Stop then cancel while STOPPING: waveform continues undisturbed
      do_reset();
      set_div(8'd4);
      start_req = 1'b1;
      tick();
      stop_req = 1'b1;
      tick();
      start_req = 1'b1;
      tick();
      capture(8, co, ri, fa, rdy, run);
      check("cancel_clk_out", co, 32'hC3);
      check("cancel_rise", ri, 32'h40);
      check("cancel_fall", fa, 32'h04);
      check("cancel_running", run, 32'hFF);

      // T5: stop during low phase, then restart
      do_reset();
      set_div(8'd4);
      start_req = 1'b1;
      tick();
      repeat (4) tick();
      check("t5_low", {clk_out, clk_fall, running}, 3'b011);
      stop_req = 1'b1;
      tick();
      check("t5_stopped", {running, clk_out, clk_rise, clk_fall}, 0);
      start_req = 1'b1;
      tick();
      check("t5_restart", {running, clk_out, clk_rise, clk_fall}, 4'b1110);

      // T6: reset mid high phase with pending full
      do_reset();
      set_div(8'd4);
      start_req = 1'b1;
      tick();
      div_valid = 1'b1; div_value = 8'd7;
      tick();
      check("t6_pending", div_ready, 0);
      rst = 1'b1;
      tick();
      check("t6_reset", {clk_out, running, div_ready, clk_fall}, 4'b0010);
      start_req = 1'b1;
      tick();
      capture(4, co, ri, fa, rdy, run);
      check("t6_clk_out", co, 32'h5);
      check("t6_fall", fa, 32'hA);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
